csr_trap_seq: RTL and testbench

Trap and return sequencer that drives the CSR register file's read and write ports as the initiating side of the CSR access interface. On a trap request it writes `mepc` and `mcause`, reads `mtvec`, and issues a pipeline redirect. On `MRET` it reads `mepc` and redirects to it. It sits beside the execute stage and is the only block that performs trap-time CSR accesses.

---
 rtl/csr_trap_seq.sv | 143 ++++++++++++++
 tb/tb_csr_trap_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer: writes mepc/mcause, reads mtvec or mepc from the CSR file,
// then issues a single-cycle pipeline redirect with flush.
module csr_trap_seq #(
  parameter logic [11:0] ADDR_MTVEC  = 12'h305,
  parameter logic [11:0] ADDR_MEPC   = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE = 12'h342
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_WAIT,
  input  logic        TRAP_REQ,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_CAUSE,
  input  logic        MRET_REQ,
  output logic        BUSY,
  output logic [11:0] CSR_RADDR,
  input  logic        CSR_RVALID,
  input  logic [31:0] CSR_RDATA,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        JUMP_EN,
  output logic [31:0] JUMP_PC,
  output logic        FLUSH
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    R_VEC   = 3'd3,
    R_EPC   = 3'd4,
    R_WAIT  = 3'd5,
    JUMP    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        isTrap_q, isTrap_d;
  logic [31:0] target_q, target_d;

  logic [31:0] base;
  logic [31:0] calcTarget;

  // Vectored mode applies only to interrupts; everything else lands on the aligned base.
  always_comb begin
    base       = CSR_RDATA & ~32'h3;
    calcTarget = base;
    if (isTrap_q && (CSR_RDATA[1:0] == 2'b01) && cause_q[31]) begin
      calcTarget = base + {cause_q[29:0], 2'b00};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      isTrap_q <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      isTrap_q <= isTrap_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    isTrap_d = isTrap_q;
    target_d = target_q;
    if (!MEM_WAIT) begin
      case (state_q)
        IDLE: begin
          if (TRAP_REQ) begin
            pc_d    = TRAP_PC[31:2];
            cause_d = TRAP_CAUSE;
            state_d = W_EPC;
          end else if (MRET_REQ) begin
            state_d = R_EPC;
          end
        end
        W_EPC:   state_d = W_CAUSE;
        W_CAUSE: state_d = R_VEC;
        R_VEC: begin
          isTrap_d = 1'b1;
          state_d  = R_WAIT;
        end
        R_EPC: begin
          isTrap_d = 1'b0;
          state_d  = R_WAIT;
        end
        R_WAIT: begin
          if (CSR_RVALID) begin
            target_d = calcTarget;
            state_d  = JUMP;
          end
        end
        JUMP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are a pure decode of registered state, so no input reaches an output combinationally.
  always_comb begin
    BUSY      = (state_q != IDLE);
    CSR_WREN  = 1'b0;
    CSR_WADDR = '0;
    CSR_WDATA = '0;
    CSR_RADDR = '0;
    JUMP_EN   = 1'b0;
    FLUSH     = 1'b0;
    JUMP_PC   = '0;
    case (state_q)
      W_EPC: begin
        CSR_WREN  = 1'b1;
        CSR_WADDR = ADDR_MEPC;
        CSR_WDATA = {pc_q, 2'b00};
      end
      W_CAUSE: begin
        CSR_WREN  = 1'b1;
        CSR_WADDR = ADDR_MCAUSE;
        CSR_WDATA = cause_q;
      end
      R_VEC:  CSR_RADDR = ADDR_MTVEC;
      R_EPC:  CSR_RADDR = ADDR_MEPC;
      R_WAIT: CSR_RADDR = isTrap_q ? ADDR_MTVEC : ADDR_MEPC;
      JUMP: begin
        JUMP_EN = 1'b1;
        FLUSH   = 1'b1;
        JUMP_PC = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: directed scenarios with literal expectations, plus a
// queue-of-steps model compared against every output on every cycle.
module tb_csr_trap_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MEM_WAIT = 1'b0;
  logic        TRAP_REQ = 1'b0;
  logic [31:0] TRAP_PC = '0;
  logic [31:0] TRAP_CAUSE = '0;
  logic        MRET_REQ = 1'b0;
  logic        BUSY;
  logic [11:0] CSR_RADDR;
  logic        CSR_RVALID = 1'b1;
  logic [31:0] CSR_RDATA = '0;
  logic        CSR_WREN;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic        JUMP_EN;
  logic [31:0] JUMP_PC;
  logic        FLUSH;

  int checks = 0;
  int errors = 0;

  csr_trap_seq dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
    .TRAP_REQ(TRAP_REQ), .TRAP_PC(TRAP_PC), .TRAP_CAUSE(TRAP_CAUSE),
    .MRET_REQ(MRET_REQ), .BUSY(BUSY), .CSR_RADDR(CSR_RADDR),
    .CSR_RVALID(CSR_RVALID), .CSR_RDATA(CSR_RDATA), .CSR_WREN(CSR_WREN),
    .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA), .JUMP_EN(JUMP_EN),
    .JUMP_PC(JUMP_PC), .FLUSH(FLUSH)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a transaction becomes a list of abstract steps; each step is what the
  // outputs must show, and a wait step is only left once read data is valid.
  typedef struct {
    logic        wren;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic        isWait;
    logic        isTrap;
    logic        jump;
    logic [31:0] jpc;
  } step_t;

  step_t       mq[$];
  logic [31:0] mCause;

  function automatic step_t mkStep(input logic wren, input logic [11:0] waddr, input logic [31:0] wdata,
                                   input logic [11:0] raddr, input logic isWait, input logic isTrap,
                                   input logic jump);
    step_t s;
    s.wren = wren; s.waddr = waddr; s.wdata = wdata; s.raddr = raddr;
    s.isWait = isWait; s.isTrap = isTrap; s.jump = jump; s.jpc = 32'h0;
    return s;
  endfunction

  function automatic logic [31:0] targetOf(input logic isTrap, input logic [31:0] rdata, input logic [31:0] cause);
    logic [31:0] base;
    base = rdata - (rdata % 4);
    if (isTrap && (rdata % 4 == 1) && cause[31])
      return base + (cause % 32'h4000_0000) * 4;
    return base;
  endfunction

  initial begin
    step_t j;
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        mq.delete();
      end else if (!MEM_WAIT) begin
        if (mq.size() == 0) begin
          if (TRAP_REQ) begin
            mCause = TRAP_CAUSE;
            mq.push_back(mkStep(1'b1, 12'h341, TRAP_PC - (TRAP_PC % 4), 12'h0, 1'b0, 1'b1, 1'b0));
            mq.push_back(mkStep(1'b1, 12'h342, TRAP_CAUSE, 12'h0, 1'b0, 1'b1, 1'b0));
            mq.push_back(mkStep(1'b0, 12'h0, 32'h0, 12'h305, 1'b0, 1'b1, 1'b0));
            mq.push_back(mkStep(1'b0, 12'h0, 32'h0, 12'h305, 1'b1, 1'b1, 1'b0));
            mq.push_back(mkStep(1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b1, 1'b1));
          end else if (MRET_REQ) begin
            mq.push_back(mkStep(1'b0, 12'h0, 32'h0, 12'h341, 1'b0, 1'b0, 1'b0));
            mq.push_back(mkStep(1'b0, 12'h0, 32'h0, 12'h341, 1'b1, 1'b0, 1'b0));
            mq.push_back(mkStep(1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 1'b1));
          end
        end else if (mq[0].isWait) begin
          if (CSR_RVALID) begin
            j = mq.pop_front();
            j = mq.pop_front();
            j.jpc = targetOf(j.isTrap, CSR_RDATA, mCause);
            mq.push_front(j);
          end
        end else begin
          void'(mq.pop_front());
        end
      end
    end
  end

  initial begin
    step_t e;
    forever begin
      @(negedge CLK);
      e = mkStep(1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 1'b0);
      if (mq.size() != 0) e = mq[0];
      checkOutput("busy", {31'b0, BUSY}, {31'b0, mq.size() != 0});
      checkOutput("wren", {31'b0, CSR_WREN}, {31'b0, e.wren});
      checkOutput("waddr", {20'b0, CSR_WADDR}, {20'b0, e.waddr});
      checkOutput("wdata", CSR_WDATA, e.wdata);
      checkOutput("raddr", {20'b0, CSR_RADDR}, {20'b0, e.raddr});
      checkOutput("jump_en", {31'b0, JUMP_EN}, {31'b0, e.jump});
      checkOutput("flush", {31'b0, FLUSH}, {31'b0, e.jump});
      checkOutput("jump_pc", JUMP_PC, e.jpc);
    end
  end

  int          epcCycle, causeCycle, jumpCycle, wrCount;
  logic [31:0] epcData, causeData, jumpPc;
  logic        jumpFlush, busyEnd;
  logic [11:0] obsRaddr [0:15];

  // Cycle c is the interval after edge c-1; the request is sampled at edge 0.
  task automatic applyStimulus(input logic trap, input logic mret, input logic [31:0] pc,
                               input logic [31:0] cause, input logic [31:0] rdata,
                               input int rvFrom, input int rvLen, input int mwFrom, input int mwLen,
                               input int reTrap, input int rstCycle, input int maxCycles);
    epcCycle = -1; causeCycle = -1; jumpCycle = -1; wrCount = 0;
    epcData = '0; causeData = '0; jumpPc = '0; jumpFlush = 1'b0;
    @(posedge CLK); #2;
    TRAP_REQ = trap; MRET_REQ = mret; TRAP_PC = pc; TRAP_CAUSE = cause;
    CSR_RDATA = rdata; CSR_RVALID = 1'b1; MEM_WAIT = 1'b0;
    for (int c = 1; c <= maxCycles; c++) begin
      @(posedge CLK); #2;
      TRAP_REQ   = (c == reTrap);
      MRET_REQ   = 1'b0;
      MEM_WAIT   = (c >= mwFrom) && (c < mwFrom + mwLen);
      CSR_RVALID = !((c >= rvFrom) && (c < rvFrom + rvLen));
      if (c == rstCycle) begin
        RST = 1'b0;
        #1;
        checkOutput("rst_busy", {31'b0, BUSY}, 32'h0);
        checkOutput("rst_raddr", {20'b0, CSR_RADDR}, 32'h0);
        checkOutput("rst_jump_en", {31'b0, JUMP_EN}, 32'h0);
        checkOutput("rst_wren", {31'b0, CSR_WREN}, 32'h0);
      end
      if (c == rstCycle + 2) RST = 1'b1;
      @(negedge CLK);
      obsRaddr[c] = CSR_RADDR;
      busyEnd = BUSY;
      if (CSR_WREN && !MEM_WAIT) begin
        wrCount++;
        if (CSR_WADDR == 12'h341 && epcCycle < 0) begin epcCycle = c; epcData = CSR_WDATA; end
        if (CSR_WADDR == 12'h342 && causeCycle < 0) begin causeCycle = c; causeData = CSR_WDATA; end
      end
      if (JUMP_EN && !MEM_WAIT && jumpCycle < 0) begin
        jumpCycle = c; jumpPc = JUMP_PC; jumpFlush = FLUSH;
      end
    end
    @(posedge CLK); #2;
    TRAP_REQ = 1'b0; MRET_REQ = 1'b0; MEM_WAIT = 1'b0; CSR_RVALID = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", {31'b0, BUSY}, 32'h0);
    checkOutput("reset_waddr", {20'b0, CSR_WADDR}, 32'h0);
    checkOutput("reset_jump_pc", JUMP_PC, 32'h0);
    @(posedge CLK); #2;
    RST = 1'b1;

    $display("[TB] direct trap");
    applyStimulus(1, 0, 32'h0000_0204, 32'd2, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("trap_epc_cycle", epcCycle, 1);
    checkOutput("trap_epc_data", epcData, 32'h0000_0204);
    checkOutput("trap_cause_cycle", causeCycle, 2);
    checkOutput("trap_cause_data", causeData, 32'd2);
    checkOutput("trap_jump_cycle", jumpCycle, 5);
    checkOutput("trap_jump_pc", jumpPc, 32'h8000_0100);
    checkOutput("trap_flush", {31'b0, jumpFlush}, 32'h1);

    $display("[TB] vectored interrupt and exception");
    applyStimulus(1, 0, 32'h0000_0403, 32'h8000_0007, 32'h8000_0101, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("vec_jump_pc", jumpPc, 32'h8000_011C);
    checkOutput("vec_epc_data", epcData, 32'h0000_0400);
    applyStimulus(1, 0, 32'h0000_0400, 32'h0000_0007, 32'h8000_0101, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("exc_jump_pc", jumpPc, 32'h8000_0100);

    $display("[TB] mret");
    applyStimulus(0, 1, 32'h0, 32'h0, 32'h0000_1236, 0, 0, 0, 0, 0, 0, 5);
    checkOutput("mret_jump_cycle", jumpCycle, 3);
    checkOutput("mret_jump_pc", jumpPc, 32'h0000_1234);
    checkOutput("mret_writes", wrCount, 0);

    $display("[TB] hazard stall");
    applyStimulus(1, 0, 32'h0000_0100, 32'd5, 32'h8000_0100, 4, 3, 0, 0, 0, 0, 10);
    checkOutput("haz_jump_cycle", jumpCycle, 8);
    for (int c = 4; c <= 7; c++) checkOutput("haz_raddr_held", {20'b0, obsRaddr[c]}, 32'h305);

    $display("[TB] trap and mret together");
    applyStimulus(1, 1, 32'h0000_0300, 32'd11, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 8);
    checkOutput("both_cause_cycle", causeCycle, 2);
    checkOutput("both_jump_pc", jumpPc, 32'h8000_0200);
    checkOutput("both_idle_after", {31'b0, busyEnd}, 32'h0);

    $display("[TB] second trap during W_CAUSE");
    applyStimulus(1, 0, 32'h0000_0500, 32'd3, 32'h8000_0100, 0, 0, 0, 0, 2, 0, 7);
    checkOutput("retrap_writes", wrCount, 2);
    checkOutput("retrap_jump_cycle", jumpCycle, 5);
    checkOutput("retrap_idle_after", {31'b0, busyEnd}, 32'h0);

    $display("[TB] reset in R_WAIT");
    applyStimulus(1, 0, 32'h0000_0600, 32'd4, 32'h8000_0100, 4, 10, 0, 0, 0, 4, 10);
    checkOutput("rst_no_jump", jumpCycle, -1);
    checkOutput("rst_idle_after", {31'b0, busyEnd}, 32'h0);

    $display("[TB] mem_wait in W_EPC");
    applyStimulus(1, 0, 32'h0000_0700, 32'd8, 32'h8000_0100, 0, 0, 1, 2, 0, 0, 9);
    checkOutput("mw_cause_cycle", causeCycle, 4);
    checkOutput("mw_jump_cycle", jumpCycle, 7);
    checkOutput("mw_writes", wrCount, 2);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
